activation_lut: RTL

Loadable sigmoid lookup table that answers activation requests from neuron blocks. It holds 2^ADDR_W entries of DATA_W bits in on-chip RAM. The table is filled by a sequential load stream. After loading, the block serves pipelined read requests with a valid/ready handshake and a fixed latency. It is the responder side of the neuron's sum-address-to-activation lookup and replaces a fixed ROM, so the activation curve can be reloaded at run time.

---
 rtl/activation_lut_pkg.sv | 25 ++
 rtl/act_lut_ram.sv | 36 +++
 rtl/activation_lut.sv | 128 ++++++++++++
 3 files changed

// File: rtl/activation_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : activation_lut_pkg
// Description : Shared state encoding, default widths and the parity helper
//               used by the loadable activation lookup table.
// Revision    : 1.0 - initial release
// ============================================================================
package activation_lut_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } lut_state_t;

    // Even-parity bit: the XOR of all data bits, so data plus this bit has an even count of ones.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_lut_ram.sv
`default_nettype none
// ============================================================================
// Module      : act_lut_ram
// Description : Simple dual-port RAM, one write port and one read port,
//               registered read data, read-before-write on address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module act_lut_ram
    import activation_lut_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WIDTH  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

    // Both ports update on the same edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/activation_lut.sv
`default_nettype none
// ============================================================================
// Module      : activation_lut
// Description : Run-time loadable sigmoid lookup table. Sequential load stream,
//               then pipelined valid/ready reads with a fixed response latency.
//               Optional per-entry parity when ACT_LUT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module activation_lut
    import activation_lut_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              table_ready,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data
`ifdef ACT_LUT_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef ACT_LUT_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] C_CNT_ONE = ADDR_W'(1);

    lut_state_t        r_state;
    logic [ADDR_W-1:0] r_load_cnt;
    logic              w_load_acc;
    logic              w_req_acc;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s2_valid;
    logic [RAM_W-1:0]  w_ram_wdata;
    logic [RAM_W-1:0]  w_ram_rdata;

    // load_start outranks everything, including a word or request in the same cycle.
    assign w_load_acc = load_valid && (r_state == ST_LOADING) && !load_start;
    assign req_ready  = (r_state == ST_READY) && !load_start;
    assign w_req_acc  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_load_cnt  <= '0;
            load_ready  <= 1'b0;
            table_ready <= 1'b0;
        end else if (load_start) begin
            r_state     <= ST_LOADING;
            r_load_cnt  <= '0;
            load_ready  <= 1'b1;
            table_ready <= 1'b0;
        end else if (w_load_acc) begin
            r_load_cnt <= r_load_cnt + C_CNT_ONE;
            if (&r_load_cnt) begin
                r_state     <= ST_READY;
                load_ready  <= 1'b0;
                table_ready <= 1'b1;
            end
        end
    end

`ifdef ACT_LUT_PARITY_EN
    assign w_ram_wdata = {even_parity(64'(load_data)), load_data};
`else
    assign w_ram_wdata = load_data;
`endif

    act_lut_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (RAM_W)
    ) u_ram (
        .clk    (clk),
        .we     (w_load_acc),
        .waddr  (r_load_cnt),
        .wdata  (w_ram_wdata),
        .re     (r_s1_valid),
        .raddr  (r_s1_addr),
        .rdata  (w_ram_rdata)
    );

    // Address register, RAM output register, then the response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            r_s1_valid <= w_req_acc;
            if (w_req_acc) begin
                r_s1_addr <= req_addr;
            end
            r_s2_valid <= r_s1_valid;
            rsp_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                rsp_data <= w_ram_rdata[DATA_W-1:0];
            end
        end
    end

`ifdef ACT_LUT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= r_s2_valid &&
                          (even_parity(64'(w_ram_rdata[DATA_W-1:0])) != w_ram_rdata[DATA_W]);
        end
    end
`endif

endmodule
`default_nettype wire
